dmem_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters: the core load/store path and a host loader/unloader port.
- The host preloads operands before a run and reads results after `done`.
- Core has fixed priority, with a starvation counter that forces a host grant after HOLD_MAX consecutive contended core grants.
- Sits between the core's load/store path and `dmem`; drives `dmem` write-enable, address and write data, and returns registered read data with a valid strobe.

---
 rtl/dmem_arbiter.sv | 62 ++++++
 tb/tb_dmem_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the core and the host, with a starvation guard for the host.
module dmem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  output logic          c_stall,
  input  logic          h_req,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  output logic          h_gnt,
  output logic          h_rvalid,
  output logic [DW-1:0] h_rdata,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic [1:0]    owner
);
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] CORE = 2'b01;
  localparam logic [1:0] HOST = 2'b10;
  localparam logic [3:0] HM = 4'(HOLD_MAX);
  logic [3:0] streak;
  logic [1:0] state;
  assign c_gnt   = reset & c_req & (~h_req | (streak < HM));
  assign h_gnt   = reset & h_req & (~c_req | (streak >= HM));
  assign c_stall = c_req & ~c_gnt;
  assign owner   = {h_gnt, c_gnt};
  assign m_we    = (c_gnt & c_we) | (h_gnt & h_we);
  assign m_addr  = c_gnt ? c_addr : h_gnt ? h_addr : '0;
  assign m_wdata = c_gnt ? c_wdata : h_gnt ? h_wdata : '0;
  always_ff @(posedge clk) begin
    if (!reset) begin
      streak   <= '0;
      state    <= IDLE;
      c_rvalid <= 1'b0;
      h_rvalid <= 1'b0;
      c_rdata  <= '0;
      h_rdata  <= '0;
    end else begin
      streak   <= (h_gnt | ~h_req) ? '0 : (c_gnt && streak < HM) ? streak + 4'd1 : streak;
      state    <= c_gnt ? CORE : h_gnt ? HOST : IDLE;
      c_rvalid <= c_gnt & ~c_we;
      h_rvalid <= h_gnt & ~h_we;
      if (c_gnt && !c_we) c_rdata <= m_rdata;
      if (h_gnt && !h_we) h_rdata <= m_rdata;
    end
  end
  // owner history is debug-only; it must never show both sides at once
  assert property (@(posedge clk) state != 2'b11);
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a behavioural dmem.
module tb_dmem_arbiter;
  logic clk = 1'b0, reset = 1'b0;
  logic c_req = 0, c_we = 0, h_req = 0, h_we = 0;
  logic [7:0] c_addr = 0, c_wdata = 0, h_addr = 0, h_wdata = 0;
  logic c_gnt, c_rvalid, c_stall, h_gnt, h_rvalid, m_we;
  logic [7:0] c_rdata, h_rdata, m_addr, m_wdata, m_rdata;
  logic [1:0] owner;
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] c_exp[$], h_exp[$];
  int n_cmp = 0, n_err = 0;
  logic g;

  dmem_arbiter #(.AW(8), .DW(8), .HOLD_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_stall(c_stall),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .owner(owner)
  );

  always #5 clk = ~clk;
  assign m_rdata = mem[m_addr];
  always @(posedge clk) if (m_we) mem[m_addr] <= m_wdata;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // reads granted just before a reset edge never return data
  always @(posedge clk) if (!reset) begin
    c_exp.delete();
    h_exp.delete();
  end

  always @(negedge clk) begin
    if (c_rvalid) begin
      if (c_exp.size() > 0) check("c_rdata", c_rdata, c_exp.pop_front());
      else check("c_rvalid_unexpected", c_rvalid, 0);
    end
    if (h_rvalid) begin
      if (h_exp.size() > 0) check("h_rdata", h_rdata, h_exp.pop_front());
      else check("h_rvalid_unexpected", h_rvalid, 0);
    end
    if (m_we && !(c_gnt || h_gnt)) check("m_we_without_gnt", m_we, 0);
    if (c_gnt && h_gnt) check("double_gnt", {c_gnt, h_gnt}, 2'b01);
    if (c_gnt && !c_we) c_exp.push_back(ref_mem[c_addr]);
    if (c_gnt && c_we) ref_mem[c_addr] = c_wdata;
    if (h_gnt && !h_we) h_exp.push_back(ref_mem[h_addr]);
    if (h_gnt && h_we) ref_mem[h_addr] = h_wdata;
  end

  task automatic next;
    @(posedge clk);
    #1;
  endtask

  logic [1:0] prio_pat [10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
  logic [1:0] clr_pat [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 2};
  logic clr_h [9] = '{1, 1, 1, 0, 1, 1, 1, 1, 1};

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'(i ^ 8'h5C);
      ref_mem[i] = 8'(i ^ 8'h5C);
    end
    for (int i = 0; i < 8; i++) begin
      mem[8'h10 + i] = 8'h50 + 8'(i);
      ref_mem[8'h10 + i] = 8'h50 + 8'(i);
    end
    for (int i = 0; i < 3; i++) begin
      mem[8'h20 + i] = 8'hA0 + 8'(i);
      ref_mem[8'h20 + i] = 8'hA0 + 8'(i);
    end
    mem[8'h30] = 8'h77;
    ref_mem[8'h30] = 8'h77;
    c_req = 1; h_req = 1; c_we = 1; h_we = 1;
    c_addr = 8'h40; h_addr = 8'h41; c_wdata = 8'hEE; h_wdata = 8'hDD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_c_gnt", c_gnt, 0);
      check("rst_h_gnt", h_gnt, 0);
      check("rst_m_we", m_we, 0);
      check("rst_rvalids", {c_rvalid, h_rvalid}, 0);
      check("rst_rdatas", {c_rdata, h_rdata}, 0);
    end
    next();
    reset = 1; c_req = 0; h_req = 0; c_we = 0;
    h_we = 1; h_req = 1; h_addr = 8'h05; h_wdata = 8'h11;
    @(negedge clk);
    check("pre_wr_gnt", h_gnt, 1);
    check("pre_wr_m_we", m_we, 1);
    next();
    h_we = 0;
    @(negedge clk);
    check("pre_rd_gnt", h_gnt, 1);
    check("pre_rd_h_rvalid", h_rvalid, 0);
    next();
    h_req = 0; c_req = 1; c_addr = 8'h05;
    @(negedge clk);
    check("pre_h_rvalid", h_rvalid, 1);
    check("pre_h_rdata", h_rdata, 8'h11);
    check("pre_c_rvalid", c_rvalid, 0);
    check("same_addr_c_gnt", c_gnt, 1);
    next();
    c_req = 0;
    @(negedge clk);
    check("same_addr_c_rvalid", c_rvalid, 1);
    check("idle_owner", owner, 0);
    check("idle_m_addr", {m_addr, m_wdata}, 0);
    next();
    c_req = 1; c_we = 0; c_addr = 8'h10; h_req = 1; h_we = 0; h_addr = 8'h30;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("prio_owner", owner, prio_pat[i]);
      check("prio_stall", c_stall, prio_pat[i] == 2);
      g = c_gnt;
      next();
      if (g) c_addr = c_addr + 1;
    end
    c_req = 0; h_req = 0;
    next();
    c_req = 1; c_addr = 8'h22;
    for (int i = 0; i < 9; i++) begin
      h_req = clr_h[i];
      @(negedge clk);
      check("clr_owner", owner, clr_pat[i]);
      next();
    end
    c_req = 0; h_req = 0;
    next();
    for (int i = 0; i < 5; i++) begin
      c_req = i < 3;
      c_addr = 8'h20 + 8'(i);
      @(negedge clk);
      check("pipe_gnt", c_gnt, i < 3);
      check("pipe_rvalid", c_rvalid, i > 0 && i < 4);
      next();
    end
    @(negedge clk);
    check("rdata_hold", c_rdata, 8'hA2);
    next();
    c_req = 1; c_we = 0; c_addr = 8'h20; h_req = 1; h_we = 0; h_addr = 8'h05;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rmid_owner", owner, 1);
      if (i == 3) begin
        #2;
        reset = 0;
      end
      next();
      c_addr = c_addr + 1;
    end
    @(negedge clk);
    check("rmid_c_rvalid", c_rvalid, 0);
    check("rmid_gnts", {c_gnt, h_gnt}, 0);
    next();
    reset = 1;
    @(negedge clk);
    check("rmid_core_first", owner, 1);
    next();
    c_req = 0; h_req = 0;
    next();
    next();
    check("c_sb_empty", c_exp.size(), 0);
    check("h_sb_empty", h_exp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
